// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: register-index width and the hazard controller's
// FSM state encoding.
package cpu_pkg;

    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned HAZ_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_INT_SEQ  = 2'd2
    } haz_state_t;

endpackage

// File: rtl/hazard_load_use_detect.sv
// Combinational load-use comparator: a load in ex-mem writes a register that the
// instruction in decode reads.
module hazard_load_use_detect
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] dec_rs,
    input  logic [REG_IDX_W-1:0] dec_rt,
    input  logic                 dec_use_rs,
    input  logic                 dec_use_rt,
    input  logic                 exm_mem_read,
    input  logic                 exm_write_back,
    input  logic [REG_IDX_W-1:0] exm_rd,
    output logic                 load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = dec_use_rs && (dec_rs == exm_rd);
    assign rt_hit   = dec_use_rt && (dec_rt == exm_rd);
    assign load_use = exm_mem_read && exm_write_back && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: load-use stalls, branch flushes, RET/RTI
// fetch freeze and interrupt entry for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned RET_LAT = 2,
    parameter int unsigned INT_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [REG_IDX_W-1:0] i_dec_rs,
    input  logic [REG_IDX_W-1:0] i_dec_rt,
    input  logic                 i_dec_use_rs,
    input  logic                 i_dec_use_rt,
    input  logic                 i_dec_pop_pc,
    input  logic                 i_exm_mem_read,
    input  logic                 i_exm_write_back,
    input  logic [REG_IDX_W-1:0] i_exm_rd,
    input  logic                 i_exm_branch_taken,
    input  logic                 i_int_req,
    output logic                 o_pc_hold,
    output logic                 o_fd_stall,
    output logic                 o_fd_flush,
    output logic                 o_de_flush,
    output logic                 o_int_inject,
    output logic                 o_int_ack,
    output logic                 o_busy
);

    localparam logic [HAZ_CNT_W-1:0] RetInit = HAZ_CNT_W'(RET_LAT - 1);
    localparam logic [HAZ_CNT_W-1:0] IntInit = HAZ_CNT_W'(INT_LAT - 1);

    haz_state_t           state_q, state_d;
    logic [HAZ_CNT_W-1:0] cnt_q, cnt_d;
    logic                 pending_q, pending_d;
    logic                 ack_q, ack_d;
    logic                 load_use;

    logic pc_hold, fd_stall, fd_flush, de_flush, int_inject, busy;

    hazard_load_use_detect u_load_use (
        .dec_rs         (i_dec_rs),
        .dec_rt         (i_dec_rt),
        .dec_use_rs     (i_dec_use_rs),
        .dec_use_rt     (i_dec_use_rt),
        .exm_mem_read   (i_exm_mem_read),
        .exm_write_back (i_exm_write_back),
        .exm_rd         (i_exm_rd),
        .load_use       (load_use)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        ack_d      = 1'b0;
        pc_hold    = 1'b0;
        fd_stall   = 1'b0;
        fd_flush   = 1'b0;
        de_flush   = 1'b0;
        int_inject = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (i_exm_branch_taken) begin
                    // Decode is squashed, so only a request survives, as pending.
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    if (i_int_req) pending_d = 1'b1;
                end else if (i_int_req || pending_q) begin
                    int_inject = 1'b1;
                    fd_flush   = 1'b1;
                    pc_hold    = 1'b1;
                    cnt_d      = IntInit;
                    state_d    = ST_INT_SEQ;
                    pending_d  = 1'b0;
                end else if (i_dec_pop_pc && !load_use) begin
                    pc_hold  = 1'b1;
                    fd_flush = 1'b1;
                    cnt_d    = RetInit;
                    state_d  = ST_RET_WAIT;
                end else if (load_use) begin
                    pc_hold  = 1'b1;
                    fd_stall = 1'b1;
                    de_flush = 1'b1;
                end
            end
            ST_RET_WAIT, ST_INT_SEQ: begin
                pc_hold  = 1'b1;
                fd_flush = 1'b1;
                busy     = 1'b1;
                if (i_int_req) pending_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                    ack_d   = (state_q == ST_INT_SEQ);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    // Combinational outputs are forced low for the whole reset cycle.
    assign o_pc_hold    = pc_hold    && !i_reset;
    assign o_fd_stall   = fd_stall   && !i_reset;
    assign o_fd_flush   = fd_flush   && !i_reset;
    assign o_de_flush   = de_flush   && !i_reset;
    assign o_int_inject = int_inject && !i_reset;
    assign o_busy       = busy       && !i_reset;
    assign o_int_ack    = ack_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Generates the stall and flush controls for the PC register, the fetch/decode buffer and the decode/ex-mem buffer. Those buffers then hold their contents or load a bubble (all control bits 0).
- Handles load-use stalls, taken-branch flushes, multi-cycle return sequences (RET/RTI, where the PC is popped from the stack) and interrupt entry.
- Sits beside the decode stage. Its inputs come from the decoder outputs and from the decode/ex-mem buffer outputs.

Parameters:
- RET_LAT, 2, cycles PC fetch stays frozen after a pop-PC instruction leaves decode (range 1..7).
- INT_LAT, 2, cycles PC fetch stays frozen after an interrupt push-PC is injected (range 1..7).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_dec_rs  in  3  decode source register 1
- i_dec_rt  in  3  decode source register 2
- i_dec_use_rs  in  1  decode instruction reads rs
- i_dec_use_rt  in  1  decode instruction reads rt
- i_dec_pop_pc  in  1  decode instruction is RET/RTI
- i_exm_mem_read  in  1  ex-mem stage instruction is a load
- i_exm_write_back  in  1  ex-mem stage instruction writes a register
- i_exm_rd  in  3  ex-mem stage destination register
- i_exm_branch_taken  in  1  branch resolved taken in ex-mem this cycle
- i_int_req  in  1  external interrupt request, level, held by the source until acked
- o_pc_hold  out  1  PC keeps its value
- o_fd_stall  out  1  fetch/decode buffer holds
- o_fd_flush  out  1  fetch/decode buffer loads a bubble
- o_de_flush  out  1  decode/ex-mem buffer loads a bubble
- o_int_inject  out  1  decoder substitutes an interrupt push-PC instruction
- o_int_ack  out  1  one-cycle interrupt acknowledge
- o_busy  out  1  FSM not in RUN

Clock is i_clk. Reset is i_reset: synchronous, active-high.

Behaviour:
- **Reset:** FSM goes to RUN, counter to 0, int_pending to 0, o_int_ack to 0. All combinational outputs evaluate to 0 while reset is asserted.
- **Output timing:** o_int_ack is registered. All other outputs are combinational from the state, the counter and the inputs.
- **load_use:** i_exm_mem_read & i_exm_write_back & ((i_dec_use_rs & rs==rd) | (i_dec_use_rt & rt==rd)).
- **FSM states:** RUN, RET_WAIT, INT_SEQ. A single down-counter is shared by RET_WAIT and INT_SEQ. Counter width is 3.

RUN, priority high to low:
1. **i_exm_branch_taken:** o_fd_flush=1, o_de_flush=1 for one cycle. Stay in RUN. A pop-PC, load-use or interrupt decision in the same cycle is discarded, because the decode instruction is squashed.
2. **Interrupt** (i_int_req | int_pending):
   - Outputs: o_int_inject=1, o_fd_flush=1, o_pc_hold=1.
   - Transitions: counter<=INT_LAT-1, go to INT_SEQ, clear int_pending.
   - A load-use in the same cycle is irrelevant: the injected instruction has no sources.
3. **i_dec_pop_pc, no load_use:**
   - Outputs: o_pc_hold=1, o_fd_flush=1. The RET itself passes into decode/ex-mem.
   - Transitions: counter<=RET_LAT-1, go to RET_WAIT.
4. **load_use:** o_pc_hold=1, o_fd_stall=1, o_de_flush=1 for exactly one cycle. Next cycle the bubble occupies ex-mem, so no repeat.
   - pop_pc with load_use: the stall is taken first. The RET is handled the following cycle.

RET_WAIT:
- Outputs every cycle: o_pc_hold=1, o_fd_flush=1, o_busy=1.
- If counter==0, go to RUN; else decrement.
- The new PC is loaded by the mem stage; this block only freezes fetch.
- i_exm_branch_taken is ignored here (no branch can be in flight behind a RET).

INT_SEQ:
- Outputs: o_pc_hold=1, o_fd_flush=1, o_busy=1.
- If counter==0: o_int_ack<=1 (next cycle, one cycle only), go to RUN. Else decrement.

Interrupt pending rules:
- int_pending<=1 when i_int_req=1 while the FSM is in RET_WAIT, INT_SEQ, or RUN with a taken branch.
- A pending interrupt is serviced on the first RUN cycle without a taken branch.

Other boundary conditions:
- RET_LAT=1 or INT_LAT=1 gives exactly one extra frozen cycle after the entry cycle.
- Reset mid-sequence aborts to RUN. A pending interrupt is lost; the source re-asserts.

Decomposition:
- The shared cpu_pkg holds the FSM state localparams (ST_RUN=2'd0, ST_RET_WAIT=2'd1, ST_INT_SEQ=2'd2) and the 3-bit register-index width.
- One sub-module, hazard_load_use_detect, is the combinational load_use comparator. It is reusable by the forwarding unit.
- The FSM and counter stay in the top.

Test Plan:
- **Load-use:** exm_mem_read=1, exm_write_back=1, exm_rd=3; dec_rs=3, use_rs=1 -> one cycle of pc_hold=fd_stall=de_flush=1. Next cycle, with exm bubble inputs, all outputs 0.
- **No false load-use:** exm_rd=3, dec_rs=3, use_rs=0, use_rt=0 -> all outputs 0. Same with exm_write_back=0 -> 0.
- **RET:** dec_pop_pc=1 for one cycle with RET_LAT=2 -> pc_hold=fd_flush=1 for 3 consecutive cycles; o_busy=1 on cycles 2-3; back to RUN on cycle 4.
- **Interrupt:** i_int_req rises in RUN -> int_inject=1 for 1 cycle; pc_hold=1 for 1+INT_LAT=3 cycles; o_int_ack=1 for exactly one cycle, the cycle after the last frozen cycle.
- **Interrupt during RET_WAIT:** i_int_req asserted 1 cycle into RET_WAIT -> RET completes; int_inject asserts on the first RUN cycle; ack follows after INT_LAT.
- **Simultaneous events:** branch_taken=1, load_use=1 and dec_pop_pc=1 in the same cycle -> only fd_flush=de_flush=1, no pc_hold, state stays RUN. Also, reset asserted in INT_SEQ -> next cycle all outputs 0 and o_busy=0.
